truth_table_sequencer: RTL and testbench

- Self-checking stimulus controller for a small combinational block with 3 inputs and 2 outputs (A, B, C -> F1, F2).
- On start, it drives every input combination 000..111 in ascending order and waits a programmable settle time for each. It then samples the outputs and compares them against an expected truth table held in parameters.
- It reports pass/fail, the error count, the first failing index and a per-vector fail map.
- It sits between a top-level test/demo wrapper and the combinational DUT, replacing open-loop stimulus.

---
 rtl/tt_seq_pkg.sv | 21 ++
 rtl/truth_table_sequencer_settle_timer.sv | 28 ++
 rtl/truth_table_sequencer.sv | 132 +++++++++++++
 tb/tb_truth_table_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_seq_pkg.sv
// Shared types and constants for the truth-table stimulus sequencer.
// Expected-table defaults describe a 3-input XOR (F1) and a 3-input majority (F2).
package tt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    localparam logic [7:0] EXP_XOR3 = 8'h96;
    localparam logic [7:0] EXP_MAJ3 = 8'hE8;

    function automatic int nv_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that holds each vector for its settle window.
// Saturates at zero; load has priority over decrement.
module settle_timer
    import tt_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input combination of a small combinational DUT, samples its outputs
// after a settle window and scores them against a parameterised truth table.
//
// state  | meaning
// IDLE   | waiting for start after reset; dut_in parked at 0
// SETTLE | holding dut_in=idx while the settle timer runs down
// SAMPLE | one cycle: compare dut_out, record result, advance or finish
// DONE   | results frozen, dut_in parked at the last vector; start restarts
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int                       N_IN          = 3,
    parameter int                       SETTLE_CYCLES = 4,
    parameter logic [(1<<N_IN)-1:0]     EXP_F1        = EXP_XOR3,
    parameter logic [(1<<N_IN)-1:0]     EXP_F2        = EXP_MAJ3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [N_IN-1:0]         dut_in,
    input  logic [1:0]              dut_out,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [N_IN:0]           err_count,
    output logic [N_IN-1:0]         first_fail,
    output logic [(1<<N_IN)-1:0]    fail_map
);

    localparam int NV = nv_of(N_IN);
    localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(NV - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t          state, state_nxt;
    logic [N_IN-1:0] idx, idx_nxt;
    logic [N_IN:0]   err_nxt;
    logic [N_IN-1:0] ff_nxt;
    logic [NV-1:0]   fm_nxt;

    logic            tmr_load;
    logic            tmr_dec;
    logic            tmr_zero;
    logic [1:0]      exp_bits;
    logic            mismatch;

    settle_timer u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (CNT_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign exp_bits = {EXP_F2[idx], EXP_F1[idx]};
    assign mismatch = (dut_out != exp_bits);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        err_nxt   = err_count;
        ff_nxt    = first_fail;
        fm_nxt    = fail_map;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    idx_nxt   = '0;
                    err_nxt   = '0;
                    ff_nxt    = '0;
                    fm_nxt    = '0;
                    tmr_load  = 1'b1;
                end
            end

            SETTLE: begin
                if (tmr_zero) begin
                    state_nxt = SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end

            SAMPLE: begin
                if (mismatch) begin
                    fm_nxt[idx] = 1'b1;
                    err_nxt     = err_count + (N_IN+1)'(1);
                    if (err_count == '0) begin
                        ff_nxt = idx;
                    end
                end
                // Terminal check precedes the increment so idx never wraps.
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                    idx_nxt   = idx + N_IN'(1);
                    tmr_load  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            fail_map   <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            err_count  <= err_nxt;
            first_fail <= ff_nxt;
            fail_map   <= fm_nxt;
        end
    end

    assign dut_in = idx;
    assign busy   = (state == SETTLE) || (state == SAMPLE);
    assign done   = (state == DONE);
    assign pass   = done && (err_count == '0);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: behavioural DUT models with fault modes,
// scoreboard of expected vector sequence and run results built from a golden model.
module tb_truth_table_sequencer;

    localparam int NV = 8;

    typedef struct {
        logic [3:0] err;
        logic [2:0] ff;
        logic [7:0] fm;
        logic       pass;
        int         run_len;
    } result_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [2:0] dut_in_a, dut_in_b;
    logic [1:0] dut_out_a, dut_out_b;
    logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [3:0] err_a, err_b;
    logic [2:0] ff_a, ff_b;
    logic [7:0] fm_a, fm_b;
    int         mode_a, mode_b;

    int n_checks = 0;
    int n_fail   = 0;

    result_t    exp_q[$];
    logic [2:0] vec_q[$];
    logic [2:0] obs_q[$];
    int         run_len_obs;
    bit         run_timeout;
    logic       first_done;

    always #5 clk = ~clk;

    // mode 0: correct, 1: F1 stuck at 0, 2: both outputs inverted
    function automatic logic [1:0] golden(input logic [2:0] v);
        logic f1, f2;
        f1 = v[2] ^ v[1] ^ v[0];
        f2 = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        return {f2, f1};
    endfunction

    function automatic logic [1:0] dut_model(input int mode, input logic [2:0] v);
        logic [1:0] g;
        g = golden(v);
        case (mode)
            1:       return {g[1], 1'b0};
            2:       return ~g;
            default: return g;
        endcase
    endfunction

    assign dut_out_a = dut_model(mode_a, dut_in_a);
    assign dut_out_b = dut_model(mode_b, dut_in_b);

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_in(dut_in_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail(ff_a), .fail_map(fm_a)
    );

    truth_table_sequencer #(.N_IN(3), .SETTLE_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_in(dut_in_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail(ff_b), .fail_map(fm_b)
    );

    task automatic push_expected(input int mode, input int settle);
        result_t r;
        r.err = '0; r.ff = '0; r.fm = '0;
        for (int i = 0; i < NV; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if (dut_model(mode, v) != golden(v)) begin
                r.fm[i] = 1'b1;
                if (r.err == 0) r.ff = v;
                r.err = r.err + 4'd1;
            end
            for (int j = 0; j < settle + 1; j++) vec_q.push_back(v);
        end
        r.pass    = (r.err == 0);
        r.run_len = NV * (settle + 1);
        exp_q.push_back(r);
    endtask

    task automatic start_and_capture(input bit sel, input int extra_at);
        obs_q.delete();
        run_len_obs = 0;
        run_timeout = 1'b0;
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        first_done = sel ? done_b : done_a;
        while (!(sel ? done_b : done_a)) begin
            if (sel ? busy_b : busy_a) obs_q.push_back(sel ? dut_in_b : dut_in_a);
            if (run_len_obs == extra_at) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(negedge clk);
            run_len_obs++;
            if (run_len_obs > 1000) begin
                run_timeout = 1'b1;
                break;
            end
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy_a, done_a, pass_a, err_a, ff_a, fm_a, dut_in_a} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_a: got busy=%b done=%b pass=%b err=%0d ff=%0d fm=%h in=%0d, want all 0",
                     busy_a, done_a, pass_a, err_a, ff_a, fm_a, dut_in_a);
        end
        n_checks++;
        if ({busy_b, done_b, pass_b, err_b, ff_b, fm_b, dut_in_b} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_b: got busy=%b done=%b err=%0d fm=%h in=%0d, want all 0",
                     busy_b, done_b, err_b, fm_b, dut_in_b);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    task automatic test_clean_run();
        result_t r;
        mode_a = 0;
        push_expected(0, 4);
        start_and_capture(1'b0, -1);
        r = exp_q.pop_front();
        n_checks++;
        if (run_timeout || run_len_obs != r.run_len) begin
            n_fail++;
            $display("FAIL clean_len: got %0d cycles (timeout=%0b) want %0d", run_len_obs, run_timeout, r.run_len);
        end
        n_checks++;
        if (obs_q.size() != vec_q.size()) begin
            n_fail++;
            $display("FAIL clean_vec_count: got %0d want %0d", obs_q.size(), vec_q.size());
        end
        while (vec_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = vec_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL clean_dut_in: got %0d want %0d", o, e);
            end
        end
        vec_q.delete();
        n_checks++;
        if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== r.pass || err_a !== r.err ||
            fm_a !== r.fm || ff_a !== r.ff || dut_in_a !== 3'd7) begin
            n_fail++;
            $display("FAIL clean_result: got done=%b busy=%b pass=%b err=%0d fm=%h ff=%0d in=%0d want 1 0 %b %0d %h %0d 7",
                     done_a, busy_a, pass_a, err_a, fm_a, ff_a, dut_in_a, r.pass, r.err, r.fm, r.ff);
        end
    endtask

    task automatic test_stuck_f1();
        result_t r;
        mode_a = 1;
        push_expected(1, 4);
        start_and_capture(1'b0, -1);
        r = exp_q.pop_front();
        vec_q.delete();
        n_checks++;
        if (run_timeout || run_len_obs != r.run_len) begin
            n_fail++;
            $display("FAIL stuck_len: got %0d want %0d", run_len_obs, r.run_len);
        end
        n_checks++;
        if (fm_a !== r.fm || err_a !== r.err || ff_a !== r.ff || pass_a !== r.pass || done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL stuck_result: got fm=%h err=%0d ff=%0d pass=%b done=%b want %h %0d %0d %b 1",
                     fm_a, err_a, ff_a, pass_a, done_a, r.fm, r.err, r.ff, r.pass);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_a !== 1'b1 || fm_a !== r.fm || dut_in_a !== 3'd7) begin
            n_fail++;
            $display("FAIL stuck_hold: got done=%b fm=%h in=%0d want 1 %h 7", done_a, fm_a, dut_in_a, r.fm);
        end
    endtask

    task automatic test_restart_from_done();
        result_t r;
        mode_a = 0;
        push_expected(0, 4);
        start_and_capture(1'b0, -1);
        r = exp_q.pop_front();
        vec_q.delete();
        n_checks++;
        if (first_done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done_drop: got done=%b after accept want 0", first_done);
        end
        n_checks++;
        if (run_timeout || run_len_obs != r.run_len) begin
            n_fail++;
            $display("FAIL restart_len: got %0d want %0d", run_len_obs, r.run_len);
        end
        n_checks++;
        if (pass_a !== 1'b1 || fm_a !== r.fm || err_a !== r.err || ff_a !== r.ff) begin
            n_fail++;
            $display("FAIL restart_result: got pass=%b fm=%h err=%0d ff=%0d want 1 %h %0d %0d",
                     pass_a, fm_a, err_a, ff_a, r.fm, r.err, r.ff);
        end
    endtask

    task automatic test_start_while_busy();
        result_t r;
        mode_a = 1;
        push_expected(1, 4);
        start_and_capture(1'b0, 15);
        r = exp_q.pop_front();
        n_checks++;
        if (run_timeout || run_len_obs != r.run_len) begin
            n_fail++;
            $display("FAIL busy_start_len: got %0d want %0d", run_len_obs, r.run_len);
        end
        n_checks++;
        if (obs_q.size() != vec_q.size()) begin
            n_fail++;
            $display("FAIL busy_start_vec_count: got %0d want %0d", obs_q.size(), vec_q.size());
        end
        while (vec_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = vec_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL busy_start_dut_in: got %0d want %0d", o, e);
            end
        end
        vec_q.delete();
        n_checks++;
        if (fm_a !== r.fm || err_a !== r.err || ff_a !== r.ff || pass_a !== r.pass) begin
            n_fail++;
            $display("FAIL busy_start_result: got fm=%h err=%0d ff=%0d pass=%b want %h %0d %0d %b",
                     fm_a, err_a, ff_a, pass_a, r.fm, r.err, r.ff, r.pass);
        end
    endtask

    task automatic test_reset_mid_run();
        mode_a = 1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b1 || err_a === 4'd0) begin
            n_fail++;
            $display("FAIL midrun_pre: got busy=%b err=%0d want busy 1 and err nonzero", busy_a, err_a);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({busy_a, done_a, pass_a, err_a, ff_a, fm_a, dut_in_a} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got busy=%b done=%b err=%0d ff=%0d fm=%h in=%0d want all 0",
                     busy_a, done_a, err_a, ff_a, fm_a, dut_in_a);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || dut_in_a !== 3'd0) begin
            n_fail++;
            $display("FAIL midrun_idle: got busy=%b in=%0d want 0 0", busy_a, dut_in_a);
        end
    endtask

    task automatic test_short_settle_inverted();
        result_t r;
        mode_b = 2;
        push_expected(2, 1);
        start_and_capture(1'b1, -1);
        r = exp_q.pop_front();
        n_checks++;
        if (run_timeout || run_len_obs != r.run_len) begin
            n_fail++;
            $display("FAIL short_len: got %0d want %0d", run_len_obs, r.run_len);
        end
        while (vec_q.size() > 0 && obs_q.size() > 0) begin
            logic [2:0] e, o;
            e = vec_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL short_dut_in: got %0d want %0d", o, e);
            end
        end
        n_checks++;
        if (vec_q.size() != 0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL short_vec_count: leftover expected=%0d observed=%0d want 0 0", vec_q.size(), obs_q.size());
        end
        vec_q.delete();
        n_checks++;
        if (err_b !== r.err || fm_b !== r.fm || ff_b !== r.ff || pass_b !== r.pass || done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL short_result: got err=%0d fm=%h ff=%0d pass=%b done=%b want %0d %h %0d %b 1",
                     err_b, fm_b, ff_b, pass_b, done_b, r.err, r.fm, r.ff, r.pass);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode_a = 0; mode_b = 0;
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b1;
        test_reset();
        test_clean_run();
        test_stuck_f1();
        test_restart_from_done();
        test_start_while_busy();
        test_reset_mid_run();
        test_clean_run();
        test_short_settle_inverted();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
